// File: rtl/param_code_detonator.sv
// Detonator control core: BCD code entry, arming, firing and a retry
// limit with a timed lockout. Keys arrive as debounced levels.
//
// state    | meaning
// IDLE     | waiting for setup key, idle lamp lit
// SETUP    | entering the arming code
// ARMED    | code stored, waiting for fire request
// ENTRY    | entering the code to detonate
// DETONATE | fired, red LED lit until wait_t
// LOCKOUT  | too many wrong codes, timed lock
module param_code_detonator #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wait_t,
  input  logic                setup,
  input  logic                ready,
  input  logic                fire,
  input  logic                sure,
  input  logic [3:0]          A,
  input  logic                confirm,
  output logic                lt,
  output logic                bt,
  output logic                rt_en,
  output logic                disp_en,
  output logic [4*DIGITS-1:0] passport,
  output logic [3:0]          tries_left,
  output logic                locked
);

  localparam int PW   = 4 * DIGITS;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam int LCW  = $clog2(LOCK_CYCLES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_ENTRY    = 3'd3;
  localparam logic [2:0] S_DETONATE = 3'd4;
  localparam logic [2:0] S_LOCKOUT  = 3'd5;

  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DIGITS);
  localparam logic [3:0]      TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [LCW-1:0]  LOCK_LOAD = LCW'(LOCK_CYCLES - 1);

  // key bit order: wait_t, confirm, sure, fire, ready, setup
  logic [5:0]      keys;
  logic [5:0]      key_prev_q, key_prev_d;
  logic [5:0]      key_evt_q, key_evt_d;
  logic [2:0]      state_q, state_d;
  logic [PW-1:0]   passport_q, passport_d;
  logic [PW-1:0]   code_q, code_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [3:0]      tries_q, tries_d;
  logic [LCW-1:0]  lock_q, lock_d;

  logic ev_wait, ev_confirm, ev_sure, ev_low, ev_fire, ev_ready, ev_setup;
  logic full, digit_ok;

  assign keys = {wait_t, confirm, sure, fire, ready, setup};

  // Rising-edge detection; the event is registered so all actions land
  // two cycles after the key rises.
  always_comb begin
    key_prev_d = keys;
    key_evt_d  = keys & ~key_prev_q;
  end

  // Only the highest-priority event of a cycle survives.
  always_comb begin
    ev_wait    = key_evt_q[5];
    ev_confirm = key_evt_q[4] & ~key_evt_q[5];
    ev_sure    = key_evt_q[3] & ~key_evt_q[4] & ~key_evt_q[5];
    ev_low     = ~|key_evt_q[5:3];
    ev_fire    = key_evt_q[2] & ev_low;
    ev_ready   = key_evt_q[1] & ev_low;
    ev_setup   = key_evt_q[0] & ev_low;
    full       = (count_q == CNT_FULL);
    digit_ok   = ev_sure & (A <= 4'd9) & ~full;
  end

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    passport_d = passport_q;
    code_d     = code_q;
    count_d    = count_q;
    tries_d    = tries_q;
    lock_d     = lock_q;
    case (state_q)
      S_IDLE: begin
        if (ev_setup) begin
          state_d    = S_SETUP;
          passport_d = '0;
          count_d    = '0;
        end
      end
      S_SETUP: begin
        if (ev_wait) begin
          state_d = S_IDLE;
        end else if (digit_ok) begin
          passport_d = (passport_q << 4) | PW'(A);
          count_d    = count_q + 1'b1;
        end else if (ev_ready && full) begin
          code_d  = passport_q;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (ev_wait) begin
          state_d = S_IDLE;
        end else if (ev_fire) begin
          state_d    = S_ENTRY;
          passport_d = '0;
          count_d    = '0;
        end
      end
      S_ENTRY: begin
        if (ev_wait) begin
          state_d = S_IDLE;
        end else if (ev_confirm) begin
          if (full && (passport_q == code_q)) begin
            state_d = S_DETONATE;
          end else begin
            tries_d = tries_q - 4'd1;
            if (tries_q == 4'd1) begin
              state_d = S_LOCKOUT;
              lock_d  = LOCK_LOAD;
            end else begin
              state_d = S_ARMED;
            end
          end
        end else if (digit_ok) begin
          passport_d = (passport_q << 4) | PW'(A);
          count_d    = count_q + 1'b1;
        end
      end
      S_DETONATE: begin
        if (ev_wait) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_q == '0) begin
          state_d = S_ARMED;
          tries_d = TRIES_MAX;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // returning to idle always wipes the code and restores the retry budget
    if (ev_wait && (state_q == S_SETUP || state_q == S_ARMED || state_q == S_ENTRY ||
                    state_q == S_DETONATE)) begin
      code_d     = '0;
      passport_d = '0;
      count_d    = '0;
      tries_d    = TRIES_MAX;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q <= '0;
      key_evt_q  <= '0;
      state_q    <= S_IDLE;
      passport_q <= '0;
      code_q     <= '0;
      count_q    <= '0;
      tries_q    <= TRIES_MAX;
      lock_q     <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      key_evt_q  <= key_evt_d;
      state_q    <= state_d;
      passport_q <= passport_d;
      code_q     <= code_d;
      count_q    <= count_d;
      tries_q    <= tries_d;
      lock_q     <= lock_d;
    end
  end

  // Lamp and display decode from registered state.
  always_comb begin
    lt         = (state_q == S_IDLE);
    bt         = (state_q == S_ARMED) || (state_q == S_ENTRY);
    rt_en      = (state_q == S_DETONATE) || (state_q == S_LOCKOUT);
    disp_en    = (state_q == S_SETUP) || (state_q == S_ENTRY);
    locked     = (state_q == S_LOCKOUT);
    passport   = passport_q;
    tries_left = tries_q;
  end

endmodule

// File: tb/tb_param_code_detonator.sv
module tb_param_code_detonator;

  localparam int DIGITS = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYCLES = 16;

  localparam logic [5:0] K_WAIT = 6'b100000;
  localparam logic [5:0] K_CONF = 6'b010000;
  localparam logic [5:0] K_SURE = 6'b001000;
  localparam logic [5:0] K_FIRE = 6'b000100;
  localparam logic [5:0] K_RDY  = 6'b000010;
  localparam logic [5:0] K_SET  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  kv = '0;
  logic [3:0]  a_in = '0;
  logic        lt, bt, rt_en, disp_en, locked;
  logic [15:0] passport;
  logic [3:0]  tries_left;

  int n_vec = 0;
  int n_bad = 0;

  param_code_detonator #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .wait_t(kv[5]), .confirm(kv[4]), .sure(kv[3]), .fire(kv[2]), .ready(kv[1]), .setup(kv[0]),
    .A(a_in),
    .lt(lt), .bt(bt), .rt_en(rt_en), .disp_en(disp_en),
    .passport(passport), .tries_left(tries_left), .locked(locked)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_SETUP, M_ARMED, M_ENTRY, M_DET, M_LOCK} mstate_t;

  typedef struct packed {
    logic        lt, bt, rt_en, disp_en, locked;
    logic [15:0] passport;
    logic [3:0]  tries;
  } exp_t;

  mstate_t m_st = M_IDLE;
  int      dig[$];
  int      m_code = 0;
  int      m_tries = MAX_TRIES;
  int      m_rem = 0;
  logic [5:0] m_prev = '0, m_evt = '0;
  exp_t    expq[$];

  function automatic int pp();
    int v = 0;
    foreach (dig[i]) v = v * 16 + dig[i];
    return v & 16'hFFFF;
  endfunction

  task automatic m_idle();
    m_st = M_IDLE; dig.delete(); m_code = 0; m_tries = MAX_TRIES;
  endtask

  task automatic m_accept();
    if (a_in <= 9 && dig.size() < DIGITS) dig.push_back(int'(a_in));
  endtask

  task automatic model_step();
    bit w, c, s, low, f, r, st;
    if (rst) begin
      m_idle(); m_rem = 0; m_prev = '0; m_evt = '0;
    end else begin
      w = m_evt[5];
      c = m_evt[4] && !w;
      s = m_evt[3] && !w && !m_evt[4];
      low = !(m_evt[5] || m_evt[4] || m_evt[3]);
      f = m_evt[2] && low;
      r = m_evt[1] && low;
      st = m_evt[0] && low;
      case (m_st)
        M_IDLE:  if (st) begin m_st = M_SETUP; dig.delete(); end
        M_SETUP: if (w) m_idle();
                 else if (s) m_accept();
                 else if (r && dig.size() == DIGITS) begin m_code = pp(); m_st = M_ARMED; end
        M_ARMED: if (w) m_idle();
                 else if (f) begin m_st = M_ENTRY; dig.delete(); end
        M_ENTRY: if (w) m_idle();
                 else if (c) begin
                   if (dig.size() == DIGITS && pp() == m_code) m_st = M_DET;
                   else begin
                     m_tries = m_tries - 1;
                     if (m_tries == 0) begin m_st = M_LOCK; m_rem = LOCK_CYCLES; end
                     else m_st = M_ARMED;
                   end
                 end else if (s) m_accept();
        M_DET:   if (w) m_idle();
        M_LOCK:  begin
                   m_rem = m_rem - 1;
                   if (m_rem == 0) begin m_st = M_ARMED; m_tries = MAX_TRIES; end
                 end
        default: m_idle();
      endcase
      m_evt = kv & ~m_prev;
      m_prev = kv;
    end
  endtask

  // Model advances on every clock edge and queues what the DUT should show.
  always @(posedge clk) begin
    exp_t e;
    model_step();
    e.lt = (m_st == M_IDLE);
    e.bt = (m_st == M_ARMED) || (m_st == M_ENTRY);
    e.rt_en = (m_st == M_DET) || (m_st == M_LOCK);
    e.disp_en = (m_st == M_SETUP) || (m_st == M_ENTRY);
    e.locked = (m_st == M_LOCK);
    e.passport = 16'(pp());
    e.tries = 4'(m_tries);
    expq.push_back(e);
  end

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e, act;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      act = '{lt, bt, rt_en, disp_en, locked, passport, tries_left};
      n_vec++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t act lt%b bt%b rt%b de%b lk%b pp=%h tr=%0d exp lt%b bt%b rt%b de%b lk%b pp=%h tr=%0d",
                 $time, act.lt, act.bt, act.rt_en, act.disp_en, act.locked, act.passport, act.tries,
                 e.lt, e.bt, e.rt_en, e.disp_en, e.locked, e.passport, e.tries);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic press(logic [5:0] m, logic [3:0] a = 4'd0);
    @(negedge clk); kv = m; a_in = a;
    @(negedge clk); kv = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter(int d0, int d1, int d2, int d3);
    press(K_SURE, 4'(d0)); press(K_SURE, 4'(d1));
    press(K_SURE, 4'(d2)); press(K_SURE, 4'(d3));
  endtask

  task automatic arm_1234();
    press(K_SET); enter(1, 2, 3, 4); press(K_RDY);
  endtask

  task automatic fail_once();
    press(K_FIRE); enter(1, 2, 3, 5); press(K_CONF);
  endtask

  initial begin
    int lk;
    repeat (3) @(negedge clk);
    chk("reset_lt", lt, 1);
    chk("reset_tries", tries_left, MAX_TRIES);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: program code 1234
    press(K_SET); enter(1, 2, 3, 4);
    chk("setup_passport", passport, 16'h1234);
    chk("setup_disp", disp_en, 1);
    press(K_RDY);
    chk("armed_bt", bt, 1);
    chk("armed_lt", lt, 0);

    // 2: correct code, detonation latency
    press(K_FIRE); enter(1, 2, 3, 4);
    @(negedge clk); kv = K_CONF;
    @(posedge clk); #1 chk("det_lat1", rt_en, 0);
    @(posedge clk); #1 chk("det_lat2", rt_en, 1);
    @(negedge clk); kv = '0;
    repeat (3) @(negedge clk);
    press(K_WAIT);
    chk("det_wait_lt", lt, 1);
    chk("det_wait_rt", rt_en, 0);
    chk("det_wait_tries", tries_left, 3);

    // 3: three failures and lockout, wait_t ignored while locked
    arm_1234();
    fail_once(); chk("tries_2", tries_left, 2); chk("fail_armed", bt, 1);
    fail_once(); chk("tries_1", tries_left, 1);
    press(K_FIRE); enter(1, 2, 3, 5);
    @(negedge clk); kv = K_CONF;
    @(negedge clk); kv = '0;
    lk = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      kv = (i == 5) ? K_WAIT : 6'b0;
      if (locked) lk++;
    end
    chk("lock_cycles", lk, LOCK_CYCLES);
    chk("lock_exit_bt", bt, 1);
    chk("lock_exit_tries", tries_left, 3);

    // 4: setup boundaries
    press(K_WAIT); press(K_SET);
    press(K_SURE, 4'hC);
    chk("digit_c_ignored", passport, 0);
    press(K_SURE, 4'd1); press(K_SURE, 4'd2); press(K_SURE, 4'd3);
    press(K_RDY);
    chk("ready3_ignored", disp_en, 1);
    press(K_SURE, 4'd4); press(K_SURE, 4'd5);
    chk("fifth_digit", passport, 16'h1234);

    // 5: same-cycle priority
    press(K_RDY); press(K_FIRE); enter(1, 2, 3, 4);
    press(K_SURE | K_CONF, 4'd5);
    chk("conf_over_sure", rt_en, 1);
    press(K_WAIT);
    arm_1234(); press(K_FIRE); enter(1, 2, 3, 4);
    press(K_WAIT | K_CONF);
    chk("wait_over_conf", lt, 1);

    // 6: async reset during lockout, held sure key
    arm_1234(); fail_once(); fail_once();
    press(K_FIRE); enter(1, 2, 3, 5);
    @(negedge clk); kv = K_CONF;
    @(negedge clk); kv = '0;
    repeat (6) @(negedge clk);
    chk("pre_rst_locked", locked, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_lt", lt, 1);
    chk("arst_rt", rt_en, 0);
    chk("arst_tries", tries_left, 3);
    @(negedge clk); rst = 1'b0;
    press(K_SET);
    @(negedge clk); kv = K_SURE; a_in = 4'd7;
    repeat (100) @(negedge clk);
    kv = '0;
    repeat (3) @(negedge clk);
    chk("held_sure", passport, 16'h0007);

    // random phase against the model
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 6; b++) kv[b] = ($urandom_range(0, 5) == 0);
      if (i % 300 < 150) kv[5] = 1'b0;
      a_in = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
    end
    kv = '0; rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
